// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: drives one register-to-register operation at a time into the
// 2-entry register file. It reads both operands, computes the result, writes it
// back to dst, and returns the result and flags over a valid/ready response.
// Optional build macro: RFSEQ_SATURATE_EN. When it is defined, ADD and SUB clamp
// instead of wrapping. The default build wraps modulo 2**DATA_W.
module rf_op_sequencer #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned ADDR_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W-1:0] req_src,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_carry,
  output logic              resp_zero,
  output logic [ADDR_W-1:0] rf_read_reg,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2
);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWrite, StDone} state_e;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  // Result and carry/borrow from the captured operands, including the optional clamp.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = a_q - b_q;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OpAdd: begin
        alu_carry = sum[DATA_W];
        alu_res   = sum[DATA_W-1:0];
`ifdef RFSEQ_SATURATE_EN
        if (alu_carry) alu_res = '1;
`else
`endif
      end
      OpSub: begin
        alu_carry = (a_q < b_q);
        alu_res   = diff;
`ifdef RFSEQ_SATURATE_EN
        if (alu_carry) alu_res = '0;
`else
`endif
      end
      OpAnd:   alu_res = a_q & b_q;
      default: alu_res = b_q;
    endcase
  end

  // Sequencer FSM. All file-side and response outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= 2'b00;
      a_q           <= '0;
      b_q           <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_carry    <= 1'b0;
      resp_zero     <= 1'b0;
      rf_read_reg   <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            // rf_write_reg/rf_read_reg double as the latched dst/src.
            op_q         <= req_op;
            rf_write_reg <= req_dst;
            rf_read_reg  <= req_src;
            req_ready    <= 1'b0;
            state_q      <= StRead;
          end
        end
        StRead: begin
          a_q          <= rf_rd_data1;
          b_q          <= rf_rd_data2;
          // Enable rises one cycle ahead of the data so edge-triggered files also catch it.
          rf_reg_write <= 1'b1;
          state_q      <= StExec;
        end
        StExec: begin
          rf_write_data <= alu_res;
          state_q       <= StWrite;
        end
        StWrite: begin
          rf_reg_write <= 1'b0;
          resp_valid   <= 1'b1;
          resp_data    <= alu_res;
          resp_carry   <= alu_carry;
          resp_zero    <= (alu_res == '0);
          state_q      <= StDone;
        end
        StDone: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Randomized self-checking bench for rf_op_sequencer. It includes a behavioural
// register file and an arithmetic reference model.
module tb_rf_op_sequencer;

  localparam int unsigned DATA_W = 5;
  localparam int unsigned ADDR_W = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_dst, req_src;
  logic              resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_carry, resp_zero;
  logic [ADDR_W-1:0] rf_read_reg, rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_reg_write;
  logic [DATA_W-1:0] rf_rd_data1, rf_rd_data2;

  logic [DATA_W-1:0] rf_mem [2];
  logic              load_en;
  logic [DATA_W-1:0] load0, load1;

  int total = 0;
  int bad   = 0;

  rf_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_dst       (req_dst),
    .req_src       (req_src),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_carry    (resp_carry),
    .resp_zero     (resp_zero),
    .rf_read_reg   (rf_read_reg),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
    .rf_rd_data1   (rf_rd_data1),
    .rf_rd_data2   (rf_rd_data2)
  );

  always #5 clk = ~clk;

  // Behavioural register file: combinational reads, write on the clock edge when enabled.
  assign rf_rd_data1 = rf_mem[rf_write_reg];
  assign rf_rd_data2 = rf_mem[rf_read_reg];

  always @(posedge clk) begin
    if (load_en) begin
      rf_mem[0] <= load0;
      rf_mem[1] <= load1;
    end else if (rf_reg_write) begin
      rf_mem[rf_write_reg] <= rf_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic, written directly from the operation rules.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int res, output int carry);
    res = 0;
    carry = 0;
    case (op)
      0: begin
        carry = (a + b > 31) ? 1 : 0;
`ifdef RFSEQ_SATURATE_EN
        res = (a + b > 31) ? 31 : a + b;
`else
        res = (a + b) % 32;
`endif
      end
      1: begin
        carry = (a < b) ? 1 : 0;
`ifdef RFSEQ_SATURATE_EN
        res = (a < b) ? 0 : a - b;
`else
        res = (a - b + 32) % 32;
`endif
      end
      2: res = a & b;
      default: res = b;
    endcase
  endfunction

  task automatic preload(input int v0, input int v1);
    @(negedge clk);
    load_en = 1'b1;
    load0 = 5'(v0);
    load1 = 5'(v1);
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  // Runs one operation and holds resp_ready low for 'stall' cycles once resp_valid is seen.
  task automatic do_op(input int op, input int dst, input int src, input int stall);
    int a, b, res, carry, lat, wcnt;
    bit seen;
    @(negedge clk);
    a = int'(rf_mem[dst]);
    b = int'(rf_mem[src]);
    ref_op(op, a, b, res, carry);
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_dst   = 1'(dst);
    req_src   = 1'(src);
    check("req_ready_idle", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    wcnt = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (rf_reg_write) wcnt++;
      if (resp_valid) seen = 1;
    end
    check("latency", seen ? lat : 99, 4);
    check("wr_cycles", wcnt, 2);
    check("resp_data", 32'(resp_data), res);
    check("resp_carry", 32'(resp_carry), carry);
    check("resp_zero", 32'(resp_zero), (res == 0) ? 1 : 0);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_op    = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("stall_valid", 32'(resp_valid), 1);
      check("stall_data", 32'(resp_data), res);
      check("stall_carry", 32'(resp_carry), carry);
      check("stall_req_ready", 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_dropped", 32'(resp_valid), 0);
    check("req_ready_back", 32'(req_ready), 1);
    check("rf_writeback", 32'(rf_mem[dst]), res);
  endtask

  // Aborts an ADD during EXEC with an asynchronous reset pulse.
  task automatic reset_mid_op();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_dst   = 1'b0;
    req_src   = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("exec_wr_en", 32'(rf_reg_write), 1);
    #2 reset = 1'b1;
    #1;
    check("abort_wr_en", 32'(rf_reg_write), 0);
    check("abort_resp_valid", 32'(resp_valid), 0);
    check("abort_wr_reg", 32'(rf_write_reg), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_dst    = '0;
    req_src    = '0;
    resp_ready = 1'b0;
    load_en    = 1'b0;
    load0      = '0;
    load1      = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_wr_en", 32'(rf_reg_write), 0);
    check("rst_resp_data", 32'(resp_data), 0);
    check("rst_flags", 32'({resp_carry, resp_zero}), 0);
    check("rst_wr_data", 32'(rf_write_data), 0);
    check("rst_regs", 32'({rf_read_reg, rf_write_reg}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);

    preload(7, 5);   do_op(0, 0, 1, 0);
    preload(7, 5);   do_op(1, 1, 0, 0);
    preload(20, 15); do_op(0, 0, 1, 0);
    preload(12, 5);  do_op(2, 1, 0, 0);
    do_op(3, 0, 1, 0);
    preload(9, 9);   do_op(1, 1, 1, 6);
    preload(3, 4);   do_op(0, 0, 1, 6);
    preload(1, 2);   reset_mid_op();
    preload(10, 11); do_op(0, 0, 1, 1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) preload(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
